// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector datapath front end:
// serializer state type, default word width and counter sizing helper.
package seq_pkg;

   localparam int BITSER_WIDTH_DEFAULT = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } bitser_state_t;

   // Bits needed to count 0..value-1; never narrower than one bit.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/bitser_hold.sv
// One-entry holding register for bit_serializer.
// A load captures a word and sets full; a drain hands the word to the
// shifter and clears full. The serializer never asserts both together.
module bitser_hold
   import seq_pkg::*;
#(
   parameter int WIDTH = BITSER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             drain,
   output logic             full,
   output logic [WIDTH-1:0] data
);

   // Capture on load, release on drain; reset discards any held word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full <= 1'b0;
         data <= '0;
      end else if (load) begin
         full <= 1'b1;
         data <= load_data;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detector's inbit.
// Words arrive over valid/ready; one bit leaves per clock. A one-deep
// holding register lets consecutive words stream without an idle gap.
//
// Build option: BITSER_LSB_FIRST_EN -- when defined, word_in[0] is sent
// first (shift direction reversed); otherwise MSB first. Handshake and
// timing are identical in both builds.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | shifter empty, line held at 0, outbit_valid low
// SHIFT | shifter emitting bits, counter runs 0..WIDTH-1
//
// WIDTH is intended to lie in 2..32.
module bit_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH = BITSER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] word_in,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             outbit,
   output logic             outbit_valid,
   output logic             busy
);

   localparam int             CW       = clog2(WIDTH);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   bitser_state_t    state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hold_data;
   logic             hold_full;
   logic             accept;
   logic             last_bit;
   logic             hold_load;
   logic             hold_drain;

   // Ready depends only on the hold flop, never on word_valid.
   assign word_ready = !hold_full;
   assign accept     = word_valid && word_ready;
   assign last_bit   = (state_q == SHIFT) && (cnt_q == CNT_LAST);

   // A word goes to hold only while the shifter is busy and not about to
   // free up; on the last-bit edge an incoming word bypasses hold.
   assign hold_load  = accept && (state_q == SHIFT) && !last_bit;
   assign hold_drain = last_bit && hold_full;

   // The shifter fills with zeros behind the data and is cleared on
   // return to IDLE, so the line idles at 0 straight from a flop.
`ifdef BITSER_LSB_FIRST_EN
   assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
   assign outbit  = shreg_q[0];
`else
   assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
   assign outbit  = shreg_q[WIDTH-1];
`endif

   assign outbit_valid = (state_q == SHIFT);
   assign busy         = (state_q == SHIFT) || hold_full;

   bitser_hold #(
      .WIDTH(WIDTH)
   ) u_hold (
      .clk      (clk),
      .reset    (reset),
      .load     (hold_load),
      .load_data(word_in),
      .drain    (hold_drain),
      .full     (hold_full),
      .data     (hold_data)
   );

   // Next-state, shifter and bit-counter update.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               shreg_d = word_in;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               cnt_d = '0;
               if (hold_full) begin
                  shreg_d = hold_data;
               end else if (accept) begin
                  shreg_d = word_in;
               end else begin
                  state_d = IDLE;
                  shreg_d = '0;
               end
            end else begin
               shreg_d = shifted;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State, shifter and counter registers; reset drops any word in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (WIDTH = 8). Expected bit streams
// come from the accepted words and the bit-order rule; handshake timing
// expectations come from the documented latency and hold behaviour.
module tb_bit_serializer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] word_in;
   logic             word_valid;
   logic             word_ready;
   logic             outbit;
   logic             outbit_valid;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;

   bit_serializer #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .word_in     (word_in),
      .word_valid  (word_valid),
      .word_ready  (word_ready),
      .outbit      (outbit),
      .outbit_valid(outbit_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // i-th bit on the wire for word w.
   function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int i);
`ifdef BITSER_LSB_FIRST_EN
      return w[i];
`else
      return w[WIDTH-1-i];
`endif
   endfunction

   task automatic test_reset();
      reset      = 1'b0;
      word_valid = 1'b0;
      word_in    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (outbit !== 1'b0) begin n_bad++; $display("FAIL reset_outbit: got %b want 0", outbit); end
      n_cmp++; if (outbit_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", outbit_valid); end
      n_cmp++; if (word_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", word_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_single_word(input logic [WIDTH-1:0] w, input string tag);
      logic eb;
      @(posedge clk);
      #1;
      word_in    = w;
      word_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (word_ready !== 1'b1) begin n_bad++; $display("FAIL %s_ready: got %b want 1", tag, word_ready); end
      @(posedge clk);
      #1;
      word_valid = 1'b0;
      word_in    = WIDTH'($urandom);
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge clk);
         eb = exp_bit(w, i);
         n_cmp++;
         if (outbit_valid !== 1'b1 || outbit !== eb) begin
            n_bad++;
            $display("FAIL %s_bit%0d: got valid=%b bit=%b want valid=1 bit=%b", tag, i, outbit_valid, outbit, eb);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (outbit_valid !== 1'b0 || outbit !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_end: got valid=%b bit=%b busy=%b want 0 0 0", tag, outbit_valid, outbit, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] wa;
      logic [WIDTH-1:0] wb;
      logic             ev, eb, er, ebusy;
      wa = 8'hA5;
      wb = 8'h3C;
      @(posedge clk);
      #1;
      word_in    = wa;
      word_valid = 1'b1;
      for (int k = 0; k <= 2 * WIDTH; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) word_in = wb;
         if (k == 1) begin
            word_valid = 1'b0;
            word_in    = '0;
         end
         @(negedge clk);
         ev    = (k < 2 * WIDTH);
         eb    = (k < WIDTH) ? exp_bit(wa, k) : (k < 2 * WIDTH) ? exp_bit(wb, k - WIDTH) : 1'b0;
         er    = !(k >= 1 && k <= WIDTH - 1);
         ebusy = (k < 2 * WIDTH);
         n_cmp++;
         if (outbit_valid !== ev || outbit !== eb) begin
            n_bad++;
            $display("FAIL b2b_bit%0d: got valid=%b bit=%b want valid=%b bit=%b", k, outbit_valid, outbit, ev, eb);
         end
         n_cmp++;
         if (word_ready !== er) begin
            n_bad++;
            $display("FAIL b2b_ready%0d: got %b want %b", k, word_ready, er);
         end
         n_cmp++;
         if (busy !== ebusy) begin
            n_bad++;
            $display("FAIL b2b_busy%0d: got %b want %b", k, busy, ebusy);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] w[3];
      int               acc_cyc[3];
      int               exp_cyc[3];
      logic             got[$];
      int               idx;
      bit               started, ended, gap, take;
      logic             eb;
      idx     = 0;
      started = 0;
      ended   = 0;
      gap     = 0;
      exp_cyc = '{0, 1, WIDTH + 1};
      for (int i = 0; i < 3; i++) begin
         w[i]       = WIDTH'($urandom);
         acc_cyc[i] = -1;
      end
      @(posedge clk);
      #1;
      word_in    = w[0];
      word_valid = 1'b1;
      for (int c = 0; c < 4 * WIDTH; c++) begin
         @(negedge clk);
         if (outbit_valid === 1'b1) begin
            if (ended) gap = 1;
            started = 1;
            got.push_back(outbit);
         end else if (started) begin
            ended = 1;
         end
         take = (word_valid === 1'b1) && (word_ready === 1'b1);
         @(posedge clk);
         if (take && idx < 3) begin
            acc_cyc[idx] = c;
            idx++;
         end
         #1;
         if (idx < 3) word_in = w[idx];
         else begin
            word_valid = 1'b0;
            word_in    = '0;
         end
      end
      word_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (acc_cyc[i] != exp_cyc[i]) begin
            n_bad++;
            $display("FAIL bp_accept%0d: got cycle %0d want cycle %0d", i, acc_cyc[i], exp_cyc[i]);
         end
      end
      n_cmp++;
      if (got.size() != 3 * WIDTH) begin
         n_bad++;
         $display("FAIL bp_count: got %0d bits want %0d", got.size(), 3 * WIDTH);
      end else begin
         for (int i = 0; i < 3 * WIDTH; i++) begin
            eb = exp_bit(w[i / WIDTH], i % WIDTH);
            n_cmp++;
            if (got[i] !== eb) begin
               n_bad++;
               $display("FAIL bp_bit%0d: got %b want %b", i, got[i], eb);
            end
         end
      end
      n_cmp++;
      if (gap) begin
         n_bad++;
         $display("FAIL bp_contiguous: got a bubble in the valid run want none");
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #1;
      word_in    = 8'hFF;
      word_valid = 1'b1;
      @(posedge clk);
      #1;
      word_in = 8'hAA;
      @(posedge clk);
      #1;
      word_valid = 1'b0;
      word_in    = '0;
      @(posedge clk);
      #2;
      n_cmp++;
      if (outbit_valid !== 1'b1 || outbit !== 1'b1 || word_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL arst_pre: got valid=%b bit=%b ready=%b want 1 1 0", outbit_valid, outbit, word_ready);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (outbit !== 1'b0 || outbit_valid !== 1'b0 || word_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL arst_immediate: got bit=%b valid=%b ready=%b busy=%b want 0 0 1 0", outbit, outbit_valid, word_ready, busy);
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (outbit_valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL arst_held: got valid=%b busy=%b want 0 0", outbit_valid, busy);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      test_single_word(8'h0F, "post_reset");
   endtask

   task automatic test_idle();
      test_single_word(WIDTH'($urandom), "pre_idle");
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_cmp++;
         if (outbit !== 1'b0 || outbit_valid !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle%0d: got bit=%b valid=%b busy=%b ready=%b want 0 0 0 1", c, outbit, outbit_valid, busy, word_ready);
         end
      end
   endtask

   task automatic test_random();
      logic exp_q[$];
      logic eb;
      int   sent, cyc, n_words;
      bit   take;
      n_words = 25;
      sent    = 0;
      cyc     = 0;
      @(posedge clk);
      #1;
      word_valid = 1'b1;
      word_in    = WIDTH'($urandom);
      while (cyc < 2000 && !(sent == n_words && exp_q.size() == 0 && word_valid == 1'b0)) begin
         @(negedge clk);
         if (outbit_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL rand_extra: got unexpected bit %b at cycle %0d want none", outbit, cyc);
            end else begin
               eb = exp_q.pop_front();
               if (outbit !== eb) begin
                  n_bad++;
                  $display("FAIL rand_bit: got %b want %b at cycle %0d", outbit, eb, cyc);
               end
            end
         end else begin
            n_cmp++;
            if (outbit !== 1'b0) begin
               n_bad++;
               $display("FAIL rand_idle_level: got %b want 0 at cycle %0d", outbit, cyc);
            end
         end
         take = (word_valid === 1'b1) && (word_ready === 1'b1);
         @(posedge clk);
         if (take) begin
            for (int i = 0; i < WIDTH; i++) exp_q.push_back(exp_bit(word_in, i));
            sent++;
         end
         #1;
         if (take || word_valid == 1'b0) begin
            if (sent < n_words && $urandom_range(0, 3) != 0) begin
               word_valid = 1'b1;
               word_in    = WIDTH'($urandom);
            end else begin
               word_valid = 1'b0;
               word_in    = '0;
            end
         end
         cyc++;
      end
      word_valid = 1'b0;
      n_cmp++;
      if (sent != n_words || exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL rand_done: got sent=%0d pending=%0d want sent=%0d pending=0", sent, exp_q.size(), n_words);
      end
   endtask

   initial begin
      test_reset();
      test_single_word(8'hB0, "word_b0");
      test_single_word(8'h0D, "word_0d");
      test_back_to_back();
      test_backpressure();
      test_async_reset();
      test_idle();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
